ff_byte_stuffer: RTL and testbench
==================================

FF_BYTE_STUFFER -- requirements
Module: ff_byte_stuffer

Interface
REQ-001 The block SHALL have no parameters; word width is 32 bits and byte width is 8 bits.
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 fifo_empty  input  1  upstream 32-bit word FIFO has no words.
REQ-005 read_req  output  1  one-cycle request to pop one word from the upstream FIFO.
REQ-006 read_data  input  32  popped word, meaningful only when rdata_valid=1.
REQ-007 rdata_valid  input  1  read_data valid; arrives exactly one cycle after an accepted read_req.
REQ-008 out_byte  output  8  stuffed output byte.
REQ-009 out_valid  output  1  out_byte holds a valid byte.
REQ-010 out_ready  input  1  downstream accepts out_byte this cycle.
REQ-011 stuff_count  output  16  number of 0x00 bytes inserted since reset.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, REQ_WAIT, EMIT and STUFF.
REQ-014 IDLE: when fifo_empty=0, the FSM SHALL assert read_req for exactly one cycle and move to REQ_WAIT; when fifo_empty=1, read_req SHALL stay 0.
REQ-015 read_req SHALL never be asserted in REQ_WAIT, EMIT or STUFF, so at most one word is in flight.
REQ-016 REQ_WAIT: on rdata_valid=1 the FSM SHALL latch read_data into a word register, clear the byte index to 3, and enter EMIT.
REQ-017 REQ_WAIT: the FSM SHALL remain in REQ_WAIT until rdata_valid=1, with no timeout.
REQ-018 rdata_valid asserted outside REQ_WAIT SHALL be ignored.
REQ-019 EMIT: out_valid SHALL be 1 and out_byte SHALL equal the word bits [8*idx+7 : 8*idx]; byte order is MSB first (idx 3, 2, 1, 0).
REQ-020 out_byte and out_valid SHALL be registered, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A byte transfers only in a cycle where out_valid=1 and out_ready=1.
REQ-022 On transfer of a byte equal to 0xFF, the FSM SHALL enter STUFF.
REQ-023 On transfer of any other byte with idx>0, the FSM SHALL decrement idx and stay in EMIT.
REQ-024 On transfer of any other byte with idx=0, the FSM SHALL return to IDLE.
REQ-025 STUFF: out_byte SHALL be 0x00 and out_valid SHALL be 1.
REQ-026 On transfer in STUFF, stuff_count SHALL increment by 1, saturating at 0xFFFF.
REQ-027 On transfer in STUFF, the FSM SHALL then go to EMIT with idx-1 if idx>0, or to IDLE if idx=0.
REQ-028 Timing: with out_ready held at 1, the first byte SHALL be presented the cycle after rdata_valid.
REQ-029 Timing: a word with k bytes of 0xFF SHALL occupy 4+k consecutive output cycles.
REQ-030 Timing: IDLE-to-IDLE overhead per word SHALL be 2 cycles (IDLE plus REQ_WAIT).
REQ-031 The upstream FIFO depth SHALL not be assumed; fifo_empty SHALL be sampled only in IDLE.
REQ-032 In IDLE and REQ_WAIT, out_valid SHALL be 0 and out_byte SHALL retain its last value.
REQ-033 A 0x00 byte already present in the data SHALL NOT trigger stuffing; only 0xFF SHALL trigger stuffing.

Reset
REQ-034 While rst=0 at a clock edge, the block SHALL set state=IDLE, read_req=0, out_valid=0, out_byte=0x00, stuff_count=0, busy=0, word register=0 and idx=3.
REQ-035 Reset in any state, including mid-word or in STUFF, SHALL discard the latched word and any pending stuff byte.
REQ-036 read_req SHALL be 0 in the first cycle after rst is deasserted.

Verification
REQ-037 Word 0x12345678, out_ready=1 -> bytes 12,34,56,78 on 4 consecutive cycles; stuff_count stays 0; read_req pulses once.
REQ-038 Word 0xFF00FFAB -> bytes FF,00,00,FF,00,AB; stuff_count=2; the original 0x00 is not stuffed.
REQ-039 Word 0xFFFFFFFF -> 8 bytes FF,00,FF,00,FF,00,FF,00; stuff_count=4; FSM back in IDLE after the last transfer.
REQ-040 Word 0xAAFF1122 with out_ready=0 for 3 cycles while FF is presented -> FF held stable, then 00 follows before 11,22.
REQ-041 fifo_empty=1 for 20 cycles, then two words queued -> no read_req while empty; then exactly two single-cycle read_req pulses, each issued only from IDLE.
REQ-042 rst=0 asserted while in STUFF -> next cycle out_valid=0, stuff_count=0, busy=0; the next word restarts at its MSB byte.

Source files
------------

// File: rtl/ff_byte_stuffer_if.sv
// Word-fetch and byte-output handshake bundle for ff_byte_stuffer.
// master = the stuffer; slave = the FIFO/sink side.
interface ff_byte_stuffer_if;
    logic        fifo_empty;
    logic        read_req;
    logic [31:0] read_data;
    logic        rdata_valid;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;

    modport master (
        input  fifo_empty,
        input  read_data,
        input  rdata_valid,
        input  out_ready,
        output read_req,
        output out_byte,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output read_data,
        output rdata_valid,
        output out_ready,
        input  read_req,
        input  out_byte,
        input  out_valid
    );
endinterface

// File: rtl/ff_byte_stuffer.sv
// Pops 32-bit words, emits them MSB byte first, and inserts a 0x00
// after every 0xFF byte; counts the inserted bytes.
module ff_byte_stuffer (
    input  logic              clk,
    input  logic              rst,
    ff_byte_stuffer_if.master bus,
    output logic [15:0]       stuff_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_WAIT,
        EMIT,
        STUFF
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] word_q;
    logic [31:0] word_n;
    logic [1:0]  idx_q;
    logic [1:0]  idx_n;
    logic [7:0]  byte_q;
    logic [7:0]  byte_n;
    logic        valid_q;
    logic        valid_n;
    logic [15:0] cnt_n;
    logic        armed_q;
    logic        req;
    logic        xfer;
    logic        last;

    function automatic logic [7:0] pick(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        return w[{i, 3'b000} +: 8];
    endfunction

    // armed_q keeps read_req low in the first cycle out of reset
    assign req  = rst && armed_q && (state == IDLE) && !bus.fifo_empty;
    assign xfer = valid_q && bus.out_ready;
    assign last = (idx_q == 2'd0);

    always_comb begin
        state_n = state;
        word_n  = word_q;
        idx_n   = idx_q;
        byte_n  = byte_q;
        valid_n = valid_q;
        cnt_n   = stuff_count;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_n = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (bus.rdata_valid) begin
                    state_n = EMIT;
                    word_n  = bus.read_data;
                    idx_n   = 2'd3;
                    byte_n  = bus.read_data[31:24];
                    valid_n = 1'b1;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (byte_q == 8'hFF) begin
                        state_n = STUFF;
                        byte_n  = 8'h00;
                    end else if (!last) begin
                        idx_n  = idx_q - 2'd1;
                        byte_n = pick(word_q, idx_q - 2'd1);
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            STUFF: begin
                if (xfer) begin
                    if (stuff_count != 16'hFFFF) begin
                        cnt_n = stuff_count + 16'd1;
                    end
                    if (!last) begin
                        state_n = EMIT;
                        idx_n   = idx_q - 2'd1;
                        byte_n  = pick(word_q, idx_q - 2'd1);
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            word_q      <= 32'h0;
            idx_q       <= 2'd3;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            stuff_count <= 16'h0;
            armed_q     <= 1'b0;
        end else begin
            state       <= state_n;
            word_q      <= word_n;
            idx_q       <= idx_n;
            byte_q      <= byte_n;
            valid_q     <= valid_n;
            stuff_count <= cnt_n;
            armed_q     <= 1'b1;
        end
    end

    assign bus.read_req  = req;
    assign bus.out_byte  = byte_q;
    assign bus.out_valid = valid_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ff_byte_stuffer.sv
// Scoreboard bench for ff_byte_stuffer: FIFO model upstream,
// randomized sink downstream, expected bytes queued per word.
module tb_ff_byte_stuffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stuff_count;
    logic        busy;

    ff_byte_stuffer_if ifc ();

    ff_byte_stuffer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc.master),
        .stuff_count (stuff_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         stuffed;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] up_q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_stuff = 0;
    int          req_pulses = 0;
    int          mode = 0;
    int          stall = 0;
    bit          spur_en = 0;
    bit          pending = 0;
    bit          prev_req = 0;
    bit          lat_chk = 0;
    logic [31:0] pend_w;
    logic [7:0]  lat_b;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Reference: each byte MSB first, a 0x00 appended after every 0xFF
    function automatic void push_word(input logic [31:0] w);
        logic [7:0] b;
        up_q.push_back(w);
        for (int i = 3; i >= 0; i--) begin
            b = 8'(w >> (8 * i));
            sb.push_back('{b: b, stuffed: 1'b0});
            if (b == 8'hFF) sb.push_back('{b: 8'h00, stuffed: 1'b1});
        end
    endfunction

    // Upstream FIFO model: one-cycle read latency, optional junk rdata_valid
    initial begin : upstream
        ifc.fifo_empty  = 1'b1;
        ifc.rdata_valid = 1'b0;
        ifc.read_data   = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending = 0;
                lat_chk = 0;
                prev_req = 0;
                ifc.rdata_valid = 1'b0;
                ifc.fifo_empty = (up_q.size() == 0);
                continue;
            end
            if (lat_chk) begin
                chk("first_valid", 32'(ifc.out_valid), 32'd1);
                chk("first_byte", 32'(ifc.out_byte), 32'(lat_b));
                lat_chk = 0;
            end
            if (pending) begin
                ifc.rdata_valid = 1'b1;
                ifc.read_data = pend_w;
                pending = 0;
                lat_chk = 1;
                lat_b = pend_w[31:24];
            end else if (spur_en && ifc.out_valid &&
                         $urandom_range(0, 2) == 0) begin
                ifc.rdata_valid = 1'b1;
                ifc.read_data = $urandom;
            end else begin
                ifc.rdata_valid = 1'b0;
            end
            ifc.fifo_empty = (up_q.size() == 0);
            #1;
            if (ifc.read_req) begin
                chk("req_from_idle", 32'(busy), 32'd0);
                chk("req_single", 32'(prev_req), 32'd0);
                chk("req_nonempty", 32'(ifc.fifo_empty), 32'd0);
                req_pulses++;
                if (up_q.size() != 0) begin
                    pend_w = up_q.pop_front();
                    pending = 1;
                end
            end
            prev_req = ifc.read_req;
        end
    end

    // Sink + monitor: picks out_ready, predicts transfers, pops scoreboard
    initial begin : monitor
        logic       pv;
        logic       pr;
        logic [7:0] pb;
        exp_t       e;
        pv = 1'b0;
        pr = 1'b0;
        pb = 8'h0;
        ifc.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
                ifc.out_ready = 1'b1;
                continue;
            end
            if (pv && !pr) begin
                chk("hold_valid", 32'(ifc.out_valid), 32'd1);
                chk("hold_byte", 32'(ifc.out_byte), 32'(pb));
            end
            case (mode)
                0: ifc.out_ready = 1'b1;
                1: ifc.out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (ifc.out_valid && ifc.out_byte == 8'hFF && stall < 3) begin
                        ifc.out_ready = 1'b0;
                        stall++;
                    end else begin
                        ifc.out_ready = 1'b1;
                    end
                end
            endcase
            if (ifc.out_valid && ifc.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %h expected none", ifc.out_byte);
                end else begin
                    e = sb.pop_front();
                    chk("out_byte", 32'(ifc.out_byte), 32'(e.b));
                    if (e.stuffed) exp_stuff++;
                end
            end
            pv = ifc.out_valid;
            pr = ifc.out_ready;
            pb = ifc.out_byte;
        end
    end

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((up_q.size() != 0 || sb.size() != 0 || pending || busy)
                   && n < budget);
        if (n >= budget) fail_now(name);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_stuff"}, 32'(stuff_count), 32'(exp_stuff));
    endtask

    initial begin : main
        int p0;
        bit found;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_byte", 32'(ifc.out_byte), 32'd0);
        chk("rst_count", 32'(stuff_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(ifc.read_req), 32'd0);

        mode = 0;
        push_word(32'h12345678);
        p0 = req_pulses;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("req_after_rst", 32'(ifc.read_req), 32'd0);
        drain("plain", 200);
        chk("plain_pulses", 32'(req_pulses - p0), 32'd1);
        chk("plain_count", 32'(stuff_count), 32'd0);

        push_word(32'hFF00FFAB);
        drain("mixed", 200);
        chk("mixed_count", 32'(stuff_count), 32'd2);

        push_word(32'hFFFFFFFF);
        drain("allff", 200);
        chk("allff_count", 32'(stuff_count), 32'd6);

        mode = 2;
        stall = 0;
        push_word(32'hAAFF1122);
        drain("stall", 200);
        chk("stall_cycles", 32'(stall), 32'd3);
        chk("stall_count", 32'(stuff_count), 32'd7);
        mode = 0;

        p0 = req_pulses;
        repeat (20) begin
            @(negedge clk);
            #2;
            chk("empty_no_req", 32'(ifc.read_req), 32'd0);
        end
        push_word(32'h01020304);
        push_word(32'hFE00FF7F);
        drain("two", 300);
        chk("two_pulses", 32'(req_pulses - p0), 32'd2);

        push_word(32'hFFFFFFFF);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #2;
            if (ifc.out_valid && ifc.out_byte == 8'h00 && busy) found = 1;
        end
        if (!found) fail_now("reach_stuff");
        rst = 1'b0;
        up_q.delete();
        sb.delete();
        exp_stuff = 0;
        @(posedge clk);
        #2;
        chk("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("mid_rst_count", 32'(stuff_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_byte", 32'(ifc.out_byte), 32'd0);
        push_word(32'h12345678);
        rst = 1'b1;
        #1;
        chk("req_after_rst2", 32'(ifc.read_req), 32'd0);
        drain("restart", 200);

        mode = 1;
        spur_en = 1;
        for (int w = 0; w < 40; w++) begin
            logic [31:0] v;
            for (int k = 0; k < 4; k++) begin
                v = v << 8;
                v[7:0] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            end
            push_word(v);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain("random", 4000);
        spur_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
